// File: rtl/patid_checker_pkg.sv
// Shared types for the PATID checker: region modes, region configuration and
// a minimal AXI request/response shape used as the default link type.
package patid_checker_pkg;

    localparam int unsigned ConfAddrWidth  = 64;
    localparam int unsigned ConfPatidWidth = 4;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        TOR   = 2'd1,
        NAPOT = 2'd3
    } addr_mode_e;

    typedef struct packed {
        addr_mode_e                 mode;
        logic [ConfAddrWidth-1:0]   addr;
        logic [ConfAddrWidth-1:0]   size;
        logic [ConfPatidWidth-1:0]  patid;
    } addr_conf_t;

    typedef struct packed {
        logic [47:0] addr;
        logic [7:0]  user;
    } default_ax_t;

    typedef struct packed {
        default_ax_t aw;
        logic        aw_valid;
        default_ax_t ar;
        logic        ar_valid;
    } default_req_t;

    typedef struct packed {
        logic aw_ready;
        logic ar_ready;
    } default_rsp_t;

    function automatic logic napot_hit(input logic [ConfAddrWidth-1:0] a,
                                       input logic [ConfAddrWidth-1:0] base,
                                       input logic [ConfAddrWidth-1:0] size);
        return (a & ~size) == (base & ~size);
    endfunction

    function automatic logic tor_hit(input logic [ConfAddrWidth-1:0] a,
                                     input logic [ConfAddrWidth-1:0] lo,
                                     input logic [ConfAddrWidth-1:0] hi);
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/patid_checker_if.sv
// Address-to-PATID lookup channel between the checker and its region matchers.
interface patid_checker_if #(
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned PatidW    = 4
) ();
    logic [AddrWidth-1:0] addr;
    logic [PatidW-1:0]    patid;

    modport master (output addr, input patid);
    modport slave  (input addr, output patid);
endinterface

// File: rtl/patid_region_match.sv
// Combinational lookup: expected PATID of the lowest-index region covering an address.
module patid_region_match
    import patid_checker_pkg::*;
#(
    parameter int unsigned NumAddrConf = 8,
    parameter int unsigned AddrWidth   = 48,
    parameter int unsigned PatidW      = 4
) (
    input  addr_conf_t [NumAddrConf-1:0] addr_conf_i,
    patid_checker_if.slave               lkp
);

    logic [ConfAddrWidth-1:0] addr_ext;
    logic [ConfAddrWidth-1:0] lower;
    logic                     found;
    logic                     hit;
    logic [PatidW-1:0]        patid_d;

    assign addr_ext = ConfAddrWidth'(lkp.addr);

    // A TOR region's lower bound is the previous entry's address, whatever its mode.
    always_comb begin
        found   = 1'b0;
        hit     = 1'b0;
        lower   = '0;
        patid_d = '0;
        for (int i = 0; i < NumAddrConf; i++) begin
            case (addr_conf_i[i].mode)
                TOR:     hit = tor_hit(addr_ext, lower, addr_conf_i[i].addr);
                NAPOT:   hit = napot_hit(addr_ext, addr_conf_i[i].addr, addr_conf_i[i].size);
                default: hit = 1'b0;
            endcase
            if (hit && !found) begin
                found   = 1'b1;
                patid_d = PatidW'(addr_conf_i[i].patid);
            end
            lower = addr_conf_i[i].addr;
        end
    end

    assign lkp.patid = patid_d;

endmodule

// File: rtl/patid_checker.sv
// Passive AXI monitor comparing each AW/AR beat's user PATID against the PATID
// expected for its address; reports pulses, last values, first error and counts.
module patid_checker
    import patid_checker_pkg::*;
#(
    parameter int unsigned NumAddrConf  = 8,
    parameter int unsigned AxiAddrWidth = 48,
    parameter int unsigned AxiUserWidth = 8,
    parameter int unsigned AxiUserIdMsb = 7,
    parameter int unsigned AxiUserIdLsb = 4,
    parameter int unsigned CntWidth     = 16,
    parameter type         axi_req_t    = default_req_t,
    parameter type         axi_rsp_t    = default_rsp_t,
    localparam int unsigned PatidW      = AxiUserIdMsb - AxiUserIdLsb + 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  axi_req_t                        axi_req_i,
    input  axi_rsp_t                        axi_rsp_i,
    input  addr_conf_t [NumAddrConf-1:0]    addr_conf_i,
    input  logic                            enable_i,
    input  logic                            clear_i,
    output logic                            aw_error_o,
    output logic                            ar_error_o,
    output logic [PatidW-1:0]               aw_patid_ref_o,
    output logic [PatidW-1:0]               aw_patid_act_o,
    output logic [PatidW-1:0]               ar_patid_ref_o,
    output logic [PatidW-1:0]               ar_patid_act_o,
    output logic                            sticky_error_o,
    output logic [AxiAddrWidth-1:0]         first_err_addr_o,
    output logic                            first_err_is_ar_o,
    output logic [CntWidth-1:0]             aw_err_cnt_o,
    output logic [CntWidth-1:0]             ar_err_cnt_o
);

    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] c);
        return (&c) ? c : c + CntWidth'(1);
    endfunction

    logic [AxiAddrWidth-1:0] aw_addr, ar_addr;
    logic [AxiUserWidth-1:0] aw_user, ar_user;
    logic [PatidW-1:0]       aw_act, ar_act;
    logic                    aw_chk, ar_chk, aw_mis, ar_mis;
    logic                    unused_user_bits;

    assign aw_addr = AxiAddrWidth'(axi_req_i.aw.addr);
    assign ar_addr = AxiAddrWidth'(axi_req_i.ar.addr);
    assign aw_user = AxiUserWidth'(axi_req_i.aw.user);
    assign ar_user = AxiUserWidth'(axi_req_i.ar.user);
    assign aw_act  = aw_user[AxiUserIdMsb:AxiUserIdLsb];
    assign ar_act  = ar_user[AxiUserIdMsb:AxiUserIdLsb];
    assign unused_user_bits = ^{aw_user, ar_user};

    patid_checker_if #(.AddrWidth(AxiAddrWidth), .PatidW(PatidW)) aw_lkp ();
    patid_checker_if #(.AddrWidth(AxiAddrWidth), .PatidW(PatidW)) ar_lkp ();

    assign aw_lkp.addr = aw_addr;
    assign ar_lkp.addr = ar_addr;

    patid_region_match #(.NumAddrConf(NumAddrConf), .AddrWidth(AxiAddrWidth), .PatidW(PatidW))
        u_aw_match (.addr_conf_i(addr_conf_i), .lkp(aw_lkp));
    patid_region_match #(.NumAddrConf(NumAddrConf), .AddrWidth(AxiAddrWidth), .PatidW(PatidW))
        u_ar_match (.addr_conf_i(addr_conf_i), .lkp(ar_lkp));

    assign aw_chk = enable_i & axi_req_i.aw_valid & axi_rsp_i.aw_ready;
    assign ar_chk = enable_i & axi_req_i.ar_valid & axi_rsp_i.ar_ready;
    assign aw_mis = aw_chk & (aw_lkp.patid != aw_act);
    assign ar_mis = ar_chk & (ar_lkp.patid != ar_act);

    logic                    aw_err_q, aw_err_d, ar_err_q, ar_err_d;
    logic [PatidW-1:0]       aw_ref_q, aw_ref_d, aw_act_q, aw_act_d;
    logic [PatidW-1:0]       ar_ref_q, ar_ref_d, ar_act_q, ar_act_d;
    logic                    sticky_q, sticky_d;
    logic [AxiAddrWidth-1:0] first_addr_q, first_addr_d;
    logic                    first_is_ar_q, first_is_ar_d;
    logic [CntWidth-1:0]     aw_cnt_q, aw_cnt_d, ar_cnt_q, ar_cnt_d;

    // Clear is applied first so a mismatch in the same cycle lands on fresh state.
    always_comb begin
        aw_err_d      = aw_mis;
        ar_err_d      = ar_mis;
        aw_ref_d      = aw_chk ? aw_lkp.patid : aw_ref_q;
        aw_act_d      = aw_chk ? aw_act       : aw_act_q;
        ar_ref_d      = ar_chk ? ar_lkp.patid : ar_ref_q;
        ar_act_d      = ar_chk ? ar_act       : ar_act_q;
        sticky_d      = clear_i ? 1'b0 : sticky_q;
        first_addr_d  = clear_i ? '0   : first_addr_q;
        first_is_ar_d = clear_i ? 1'b0 : first_is_ar_q;
        aw_cnt_d      = clear_i ? '0   : aw_cnt_q;
        ar_cnt_d      = clear_i ? '0   : ar_cnt_q;
        if (aw_mis) aw_cnt_d = sat_inc(aw_cnt_d);
        if (ar_mis) ar_cnt_d = sat_inc(ar_cnt_d);
        if ((aw_mis || ar_mis) && !sticky_d) begin
            first_addr_d  = aw_mis ? aw_addr : ar_addr;
            first_is_ar_d = !aw_mis;
        end
        if (aw_mis || ar_mis) sticky_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_err_q      <= 1'b0;
            ar_err_q      <= 1'b0;
            aw_ref_q      <= '0;
            aw_act_q      <= '0;
            ar_ref_q      <= '0;
            ar_act_q      <= '0;
            sticky_q      <= 1'b0;
            first_addr_q  <= '0;
            first_is_ar_q <= 1'b0;
            aw_cnt_q      <= '0;
            ar_cnt_q      <= '0;
        end else begin
            aw_err_q      <= aw_err_d;
            ar_err_q      <= ar_err_d;
            aw_ref_q      <= aw_ref_d;
            aw_act_q      <= aw_act_d;
            ar_ref_q      <= ar_ref_d;
            ar_act_q      <= ar_act_d;
            sticky_q      <= sticky_d;
            first_addr_q  <= first_addr_d;
            first_is_ar_q <= first_is_ar_d;
            aw_cnt_q      <= aw_cnt_d;
            ar_cnt_q      <= ar_cnt_d;
        end
    end

    // A pulse still pending when reset arrives is masked rather than shown for a cycle.
    assign aw_error_o        = aw_err_q & ~rst_i;
    assign ar_error_o        = ar_err_q & ~rst_i;
    assign aw_patid_ref_o    = aw_ref_q;
    assign aw_patid_act_o    = aw_act_q;
    assign ar_patid_ref_o    = ar_ref_q;
    assign ar_patid_act_o    = ar_act_q;
    assign sticky_error_o    = sticky_q;
    assign first_err_addr_o  = first_addr_q;
    assign first_err_is_ar_o = first_is_ar_q;
    assign aw_err_cnt_o      = aw_cnt_q;
    assign ar_err_cnt_o      = ar_cnt_q;

endmodule

// File: tb/tb_patid_checker.sv
// Directed bench for patid_checker: region lookup modes, error reporting,
// counters, clear and reset behaviour.
module tb_patid_checker;
    import patid_checker_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, enable, clear;
    default_req_t         req;
    default_rsp_t         rsp;
    addr_conf_t [7:0]     conf;
    logic                 aw_error, ar_error, sticky, first_is_ar;
    logic [3:0]           aw_ref, aw_act, ar_ref, ar_act;
    logic [47:0]          first_addr;
    logic [1:0]           aw_cnt, ar_cnt;

    int checks = 0;
    int errors = 0;

    patid_checker #(
        .NumAddrConf(8), .AxiAddrWidth(48), .AxiUserWidth(8),
        .AxiUserIdMsb(7), .AxiUserIdLsb(4), .CntWidth(2),
        .axi_req_t(default_req_t), .axi_rsp_t(default_rsp_t)
    ) dut (
        .clk_i(clk), .rst_i(rst), .axi_req_i(req), .axi_rsp_i(rsp),
        .addr_conf_i(conf), .enable_i(enable), .clear_i(clear),
        .aw_error_o(aw_error), .ar_error_o(ar_error),
        .aw_patid_ref_o(aw_ref), .aw_patid_act_o(aw_act),
        .ar_patid_ref_o(ar_ref), .ar_patid_act_o(ar_act),
        .sticky_error_o(sticky), .first_err_addr_o(first_addr),
        .first_err_is_ar_o(first_is_ar),
        .aw_err_cnt_o(aw_cnt), .ar_err_cnt_o(ar_cnt)
    );

    patid_checker_if #(.AddrWidth(48), .PatidW(4)) lkp_if ();
    patid_region_match #(.NumAddrConf(8), .AddrWidth(48), .PatidW(4))
        u_lkp (.addr_conf_i(conf), .lkp(lkp_if));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_region(input int i, input addr_mode_e m, input logic [63:0] a,
                              input logic [63:0] s, input logic [3:0] p);
        conf[i].mode  = m;
        conf[i].addr  = a;
        conf[i].size  = s;
        conf[i].patid = p;
    endtask

    task automatic hs_aw(input logic [47:0] a, input logic [3:0] p);
        req.aw.addr = a; req.aw.user = {p, 4'h0}; req.aw_valid = 1'b1;
        tick();
        req.aw_valid = 1'b0;
    endtask

    task automatic hs_ar(input logic [47:0] a, input logic [3:0] p);
        req.ar.addr = a; req.ar.user = {p, 4'h0}; req.ar_valid = 1'b1;
        tick();
        req.ar_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({aw_error, ar_error, aw_ref, aw_act, ar_ref, ar_act, sticky, first_addr,
             first_is_ar, aw_cnt, ar_cnt} !== '0) begin
            errors++; $display("FAIL reset_outputs: outputs not all zero during reset");
        end
        rst = 1'b0;
        tick();
        checks++;
        if (sticky !== 1'b0 || aw_cnt !== 2'd0) begin
            errors++; $display("FAIL reset_release: sticky=%0b cnt=%0d required 0/0", sticky, aw_cnt);
        end
    endtask

    task automatic test_napot();
        conf = '0;
        set_region(0, NAPOT, 64'h2000_0000, 64'h07FF_FFFF, 4'd0);
        hs_aw(48'h2000_1000, 4'd0);
        checks++;
        if (aw_error !== 1'b0 || sticky !== 1'b0 || aw_ref !== 4'd0 || aw_act !== 4'd0) begin
            errors++; $display("FAIL napot_match: err=%0b sticky=%0b ref=%0d act=%0d required 0/0/0/0",
                               aw_error, sticky, aw_ref, aw_act);
        end
        hs_aw(48'h2000_1000, 4'd5);
        checks++;
        if (aw_error !== 1'b1 || aw_ref !== 4'd0 || aw_act !== 4'd5) begin
            errors++; $display("FAIL napot_mismatch: err=%0b ref=%0d act=%0d required 1/0/5",
                               aw_error, aw_ref, aw_act);
        end
        checks++;
        if (aw_cnt !== 2'd1 || first_addr !== 48'h2000_1000 || first_is_ar !== 1'b0 || sticky !== 1'b1) begin
            errors++; $display("FAIL napot_capture: cnt=%0d addr=%0h is_ar=%0b sticky=%0b required 1/20001000/0/1",
                               aw_cnt, first_addr, first_is_ar, sticky);
        end
        tick();
        checks++;
        if (aw_error !== 1'b0 || aw_act !== 4'd5 || aw_ref !== 4'd0) begin
            errors++; $display("FAIL pulse_hold: err=%0b act=%0d ref=%0d required 0/5/0", aw_error, aw_act, aw_ref);
        end
    endtask

    task automatic test_tor();
        conf = '0;
        set_region(0, TOR, 64'h2000_0000, 64'h0, 4'd7);
        set_region(1, TOR, 64'h4000_0000, 64'h0, 4'd6);
        set_region(2, TOR, 64'h6000_0000, 64'h0, 4'd5);
        do_clear();
        hs_ar(48'h3FFF_FFF8, 4'd6);
        checks++;
        if (ar_ref !== 4'd6 || ar_error !== 1'b0) begin
            errors++; $display("FAIL tor_below_bound: ref=%0d err=%0b required 6/0", ar_ref, ar_error);
        end
        hs_ar(48'h4000_0000, 4'd6);
        checks++;
        if (ar_ref !== 4'd5 || ar_act !== 4'd6 || ar_error !== 1'b1 || ar_cnt !== 2'd1) begin
            errors++; $display("FAIL tor_at_bound: ref=%0d act=%0d err=%0b cnt=%0d required 5/6/1/1",
                               ar_ref, ar_act, ar_error, ar_cnt);
        end
        checks++;
        if (first_is_ar !== 1'b1 || first_addr !== 48'h4000_0000) begin
            errors++; $display("FAIL tor_capture: is_ar=%0b addr=%0h required 1/40000000", first_is_ar, first_addr);
        end
        hs_ar(48'h0000_1000, 4'd7);
        checks++;
        if (ar_ref !== 4'd7 || ar_error !== 1'b0) begin
            errors++; $display("FAIL tor_region0_from_zero: ref=%0d err=%0b required 7/0", ar_ref, ar_error);
        end
        hs_ar(48'h6000_0000, 4'd3);
        checks++;
        if (ar_ref !== 4'd0 || ar_error !== 1'b1 || first_addr !== 48'h4000_0000) begin
            errors++; $display("FAIL tor_no_match: ref=%0d err=%0b first=%0h required 0/1/40000000",
                               ar_ref, ar_error, first_addr);
        end
    endtask

    task automatic test_priority();
        conf = '0;
        set_region(0, OFF,   64'h1000_0000, 64'h0FFF_FFFF, 4'd1);
        set_region(1, NAPOT, 64'h1000_0000, 64'h0000_FFFF, 4'd3);
        set_region(2, NAPOT, 64'h1000_0000, 64'h0FFF_FFFF, 4'd9);
        hs_aw(48'h1000_0100, 4'd3);
        checks++;
        if (aw_ref !== 4'd3 || aw_error !== 1'b0) begin
            errors++; $display("FAIL overlap_lowest_index: ref=%0d err=%0b required 3/0", aw_ref, aw_error);
        end
        hs_aw(48'h1001_0000, 4'd9);
        checks++;
        if (aw_ref !== 4'd9 || aw_error !== 1'b0) begin
            errors++; $display("FAIL overlap_second_region: ref=%0d err=%0b required 9/0", aw_ref, aw_error);
        end
        lkp_if.addr = 48'h1001_0000;
        #1;
        checks++;
        if (lkp_if.patid !== 4'd9) begin
            errors++; $display("FAIL lookup_direct: patid=%0d required 9", lkp_if.patid);
        end
        lkp_if.addr = 48'h3000_0000;
        #1;
        checks++;
        if (lkp_if.patid !== 4'd0) begin
            errors++; $display("FAIL lookup_default: patid=%0d required 0", lkp_if.patid);
        end
    endtask

    task automatic test_both_channels();
        conf = '0;
        set_region(0, NAPOT, 64'h2000_0000, 64'h07FF_FFFF, 4'd0);
        do_clear();
        req.aw.addr = 48'h2000_1000; req.aw.user = 8'h50; req.aw_valid = 1'b1;
        req.ar.addr = 48'h2000_3000; req.ar.user = 8'h40; req.ar_valid = 1'b1;
        tick();
        req.aw_valid = 1'b0; req.ar_valid = 1'b0;
        checks++;
        if (aw_error !== 1'b1 || ar_error !== 1'b1 || aw_cnt !== 2'd1 || ar_cnt !== 2'd1) begin
            errors++; $display("FAIL both_counts: errs=%0b%0b cnts=%0d/%0d required 11 1/1",
                               aw_error, ar_error, aw_cnt, ar_cnt);
        end
        checks++;
        if (first_is_ar !== 1'b0 || first_addr !== 48'h2000_1000) begin
            errors++; $display("FAIL both_first_aw: is_ar=%0b addr=%0h required 0/20001000", first_is_ar, first_addr);
        end
    endtask

    task automatic test_enable_ready();
        enable = 1'b0;
        hs_aw(48'h2000_1000, 4'd9);
        enable = 1'b1;
        checks++;
        if (aw_error !== 1'b0 || aw_cnt !== 2'd1 || aw_act !== 4'd5) begin
            errors++; $display("FAIL disabled_no_check: err=%0b cnt=%0d act=%0d required 0/1/5", aw_error, aw_cnt, aw_act);
        end
        rsp.aw_ready = 1'b0;
        hs_aw(48'h2000_1000, 4'd9);
        rsp.aw_ready = 1'b1;
        checks++;
        if (aw_error !== 1'b0 || aw_cnt !== 2'd1 || aw_act !== 4'd5) begin
            errors++; $display("FAIL no_ready_no_check: err=%0b cnt=%0d act=%0d required 0/1/5", aw_error, aw_cnt, aw_act);
        end
    endtask

    task automatic test_back_to_back_saturation();
        do_clear();
        req.aw.addr = 48'h2000_1000; req.aw.user = 8'h50; req.aw_valid = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            tick();
            checks++;
            if (aw_error !== 1'b1 || aw_cnt !== ((n > 3) ? 2'd3 : 2'(n))) begin
                errors++; $display("FAIL saturate_step%0d: err=%0b cnt=%0d required 1/%0d",
                                   n, aw_error, aw_cnt, (n > 3) ? 3 : n);
            end
        end
        req.aw.addr = 48'h2000_2000;
        clear = 1'b1;
        tick();
        clear = 1'b0; req.aw_valid = 1'b0;
        checks++;
        if (aw_cnt !== 2'd1 || sticky !== 1'b1 || first_addr !== 48'h2000_2000 || ar_cnt !== 2'd0) begin
            errors++; $display("FAIL clear_with_mismatch: cnt=%0d sticky=%0b addr=%0h arcnt=%0d required 1/1/20002000/0",
                               aw_cnt, sticky, first_addr, ar_cnt);
        end
    endtask

    task automatic test_reset_midop();
        req.aw.addr = 48'h2000_1000; req.aw.user = 8'h70; req.aw_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1; req.aw_valid = 1'b0;
        #1;
        checks++;
        if (aw_error !== 1'b0) begin
            errors++; $display("FAIL reset_suppress_pulse: err=%0b required 0", aw_error);
        end
        tick();
        checks++;
        if ({aw_error, ar_error, aw_ref, aw_act, ar_ref, ar_act, sticky, first_addr,
             first_is_ar, aw_cnt, ar_cnt} !== '0) begin
            errors++; $display("FAIL reset_midop_outputs: cnt=%0d sticky=%0b act=%0d required all zero",
                               aw_cnt, sticky, aw_act);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (aw_error !== 1'b0 || aw_cnt !== 2'd0) begin
            errors++; $display("FAIL reset_drop_beat: err=%0b cnt=%0d required 0/0", aw_error, aw_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; clear = 1'b0;
        req = '0; rsp = '0; conf = '0;
        rsp.aw_ready = 1'b1; rsp.ar_ready = 1'b1;
        lkp_if.addr = '0;
        test_reset();
        test_napot();
        test_tor();
        test_priority();
        test_both_channels();
        test_enable_ready();
        test_back_to_back_saturation();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete within 50000 time units");
        $fatal(1);
    end

endmodule

// File: doc/patid_checker.md
PATID_CHECKER -- requirements
Module: patid_checker

Interface
REQ-001 SHALL have parameter NumAddrConf, default 8, number of address-configuration regions (1..16).
REQ-002 SHALL have parameter AxiAddrWidth, default 48, AXI address width.
REQ-003 SHALL have parameter AxiUserWidth, default 8, AXI user width.
REQ-004 SHALL have parameters AxiUserIdMsb / AxiUserIdLsb, default 7 / 4, PATID field position inside ax.user.
REQ-005 SHALL have parameter CntWidth, default 16, width of the saturating error counters.
REQ-006 SHALL have type parameters axi_req_t and axi_rsp_t, the AXI request and response structs.
REQ-007 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-008 rst_i  in  1  reset, synchronous, active-high.
REQ-009 axi_req_i / axi_rsp_i  in  struct  monitored AXI link, sampled only.
REQ-010 addr_conf_i  in  NumAddrConf x addr_conf_t  per-region {mode, addr, size, patid}.
REQ-011 enable_i  in  1  checking enabled; when low, no checks, errors or counts.
REQ-012 clear_i  in  1  single-cycle clear of sticky state and counters.
REQ-013 aw_error_o / ar_error_o  out  1  one-cycle mismatch pulse per channel.
REQ-014 aw_patid_ref_o, aw_patid_act_o, ar_patid_ref_o, ar_patid_act_o  out  PATID width  expected and actual PATID of the last checked beat.
REQ-015 sticky_error_o  out  1  set on any mismatch, held until clear_i or reset.
REQ-016 first_err_addr_o  out  AxiAddrWidth  address of the first mismatch since clear.
REQ-017 first_err_is_ar_o  out  1  channel of the first mismatch (1 = AR).
REQ-018 aw_err_cnt_o / ar_err_cnt_o  out  CntWidth  saturating mismatch counts.

Function
REQ-019 A check SHALL occur only on an AW (aw_valid & aw_ready) or AR (ar_valid & ar_ready) handshake while enable_i is high.
REQ-020 Region mode OFF SHALL never match.
REQ-021 Region mode TOR SHALL match when addr[i-1] <= A < addr[i], where the lower bound of region 0 is 0.
REQ-022 Region mode NAPOT SHALL match when (A & ~size) == (addr & ~size).
REQ-023 The expected PATID SHALL be the patid of the lowest-index matching region, or 0 if no region matches.
REQ-024 The actual PATID SHALL be user[AxiUserIdMsb:AxiUserIdLsb].
REQ-025 Results SHALL be registered: the error pulse and the ref/act outputs update exactly 1 cycle after the handshake.
REQ-026 ref/act outputs SHALL update on every check and hold otherwise.
REQ-027 AW and AR SHALL be checked independently and may both be checked in the same cycle.
REQ-028 When AW and AR mismatch in the same cycle with no prior error, the first-error capture SHALL record AW.
REQ-029 Counters SHALL increment by 1 per mismatch and saturate at all-ones without wrapping.
REQ-030 clear_i SHALL zero the counters and sticky state; a mismatch registered in the same cycle SHALL apply after the clear (counter = 1, sticky set, new capture).
REQ-031 A configuration change SHALL affect only handshakes that occur after it.

Reset
REQ-032 On reset, all outputs SHALL be 0 one cycle after rst_i is sampled high, and every checked beat in flight SHALL be dropped.
REQ-033 Assertion of reset mid-operation SHALL suppress any error pulse pending from the preceding cycle's handshake.

Structure
REQ-034 Package patid_checker_pkg SHALL define addr_mode_e (OFF = 0, TOR = 1, NAPOT = 3) and the parametrised fields of addr_conf_t.
REQ-035 Sub-module patid_region_match SHALL implement the combinational address-to-PATID lookup and SHALL be instantiated once per channel.

Verification
REQ-036 Region 0 NAPOT {0x2000_0000, 0x07FF_FFFF, patid 0}; AW 0x2000_1000 with user PATID 0 -> no error. The same AW with PATID 5 -> aw_error_o pulses 1 cycle later, ref = 0, act = 5, aw_err_cnt_o = 1, first_err_addr_o = 0x2000_1000.
REQ-037 TOR bounds 0x2000_0000 / 0x4000_0000 / 0x6000_0000 with patids 7 / 6 / 5; AR 0x3FFF_FFF8 -> ref 6; AR 0x4000_0000 -> ref 5.
REQ-038 Overlapping NAPOT regions 1 and 2 both match the address -> ref equals region 1 patid.
REQ-039 AW and AR mismatch in the same cycle after clear -> both counts = 1, first_err_is_ar_o = 0.
REQ-040 CntWidth = 2 with 5 AW mismatches -> aw_err_cnt_o = 3; clear_i asserted together with a 6th mismatch -> aw_err_cnt_o = 1.
REQ-041 rst_i asserted the cycle after a mismatching handshake -> no error pulse and all outputs 0.
